// File: rtl/fb_write_ctrl.sv
// ---------------------------------------------------------------------------
// fb_write_ctrl
//
// Purpose:
//   Sits downstream of the SPI slave and turns its command/window/pixel
//   pulses into framebuffer write requests. The CASET/RASET window is
//   latched here, an (x,y) cursor walks that window as RAMWR pixels arrive,
//   and every pixel becomes an {address, data} entry in a small FIFO that
//   the framebuffer RAM arbiter drains through a valid/ready port.
//
// Parameters:
//   H_RES       panel width in pixels, also the row stride
//   V_RES       panel height in pixels
//   ADDR_W      framebuffer word address width
//   FIFO_DEPTH  write FIFO entries (power of 2, at least 2)
//
// Ports:
//   i_clk              system clock (shared with the SPI slave core side)
//   i_rst              asynchronous active-high reset
//   i_inst_data        last command byte
//   i_inst_en_pls      command byte valid pulse
//   i_col_addr         {XS, XE} column window
//   i_col_addr_en_pls  column window valid pulse
//   i_row_addr         {YS, YE} row window
//   i_row_addr_en_pls  row window valid pulse
//   i_pixel_data       RGB565 pixel
//   i_pixel_en_pls     pixel valid pulse
//   o_wr_addr          FIFO head word address (0 while the FIFO is empty)
//   o_wr_data          FIFO head pixel data (0 while the FIFO is empty)
//   o_wr_valid         FIFO not empty
//   i_wr_ready         arbiter takes the head entry when valid and ready
//   o_frame_done_pls   one-cycle pulse after the cursor wraps past (XE,YE)
//   o_ovf              sticky flag, a pixel was dropped on a full FIFO
//
// Configuration macro:
//   FB_BOUNDS_CHECK_EN  when defined, pixels whose cursor lies outside the
//                       panel are discarded instead of aliasing into the
//                       framebuffer; the cursor keeps advancing either way.
// ---------------------------------------------------------------------------
module fb_write_ctrl #(
   parameter int H_RES      = 480,
   parameter int V_RES      = 272,
   parameter int ADDR_W     = 17,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [7:0]        i_inst_data,
   input  logic              i_inst_en_pls,
   input  logic [31:0]       i_col_addr,
   input  logic              i_col_addr_en_pls,
   input  logic [31:0]       i_row_addr,
   input  logic              i_row_addr_en_pls,
   input  logic [15:0]       i_pixel_data,
   input  logic              i_pixel_en_pls,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [15:0]       o_wr_data,
   output logic              o_wr_valid,
   input  logic              i_wr_ready,
   output logic              o_frame_done_pls,
   output logic              o_ovf
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [7:0]        CMD_RAMWR = 8'h2C;
   localparam logic [15:0]       X_LAST    = 16'(H_RES - 1);
   localparam logic [15:0]       Y_LAST    = 16'(V_RES - 1);
   localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(H_RES);

   typedef enum logic [2:0] {
      CUR_HOLD,
      CUR_HOME,
      CUR_STEP_X,
      CUR_NEXT_ROW,
      CUR_WRAP
   } cursor_action_t;

   logic [15:0]       winXs, winXe, winYs, winYe;
   logic [ADDR_W-1:0] ysBase;
   logic [15:0]       curX, curY;
   logic [ADDR_W-1:0] rowBase;
   cursor_action_t    curAction;
   logic              frameDone;
   logic              ovfFlag;

   logic [15:0]       colXsNew, colXeNew, rowYsNew, rowYeNew;
   logic [ADDR_W-1:0] ysBaseNew;
   logic              cmdRamwr;
   logic              pixelLive;
   logic              inBounds;
   logic [ADDR_W-1:0] pixAddr;

   logic [ADDR_W-1:0] memAddr [FIFO_DEPTH];
   logic [15:0]       memData [FIFO_DEPTH];
   logic [PTR_W-1:0]  wrPtr, rdPtr;
   logic [CNT_W-1:0]  fifoCount;
   logic              fifoFull, fifoPop, wantPush, fifoPush, dropPixel;

   // Decode the incoming window pulses. An end coordinate below its start is
   // clamped up to the start so the cursor never walks an empty range. The
   // row start is also turned into a framebuffer offset here, once, so the
   // pixel path only ever needs an adder.
   always_comb begin
      colXsNew  = i_col_addr[31:16];
      colXeNew  = (i_col_addr[15:0] < i_col_addr[31:16]) ? i_col_addr[31:16] : i_col_addr[15:0];
      rowYsNew  = i_row_addr[31:16];
      rowYeNew  = (i_row_addr[15:0] < i_row_addr[31:16]) ? i_row_addr[31:16] : i_row_addr[15:0];
      ysBaseNew = ADDR_W'(32'(rowYsNew) * 32'(H_RES));
   end

   // Window registers. They update on the same edge a simultaneous pixel is
   // consumed, so that pixel still sees the old window and the new one takes
   // effect from the following pixel.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         winXs  <= '0;
         winXe  <= X_LAST;
         winYs  <= '0;
         winYe  <= Y_LAST;
         ysBase <= '0;
      end else begin
         if (i_col_addr_en_pls) begin
            winXs <= colXsNew;
            winXe <= colXeNew;
         end
         if (i_row_addr_en_pls) begin
            winYs  <= rowYsNew;
            winYe  <= rowYeNew;
            ysBase <= ysBaseNew;
         end
      end
   end

   // Pixel qualification. A RAMWR command arriving with a pixel takes
   // priority and swallows that pixel, which is not an overflow. The write
   // address is the current row offset plus x, truncated to the RAM width.
   always_comb begin
      cmdRamwr  = i_inst_en_pls && (i_inst_data == CMD_RAMWR);
      pixelLive = i_pixel_en_pls && !cmdRamwr;
      pixAddr   = rowBase + ADDR_W'(curX);
   end

`ifdef FB_BOUNDS_CHECK_EN
   // Off-panel coordinates are discarded rather than wrapped into RAM.
   assign inBounds = (curX < 16'(H_RES)) && (curY < 16'(V_RES));
`else
   // Every pixel is written; off-panel coordinates alias within the RAM.
   assign inBounds = 1'b1;
`endif

   // Choose what the cursor does this cycle. Dropped pixels (FIFO full or
   // off-panel) still advance the cursor so the image stays aligned with
   // the host's idea of where it is writing.
   always_comb begin
      curAction = CUR_HOLD;
      if (cmdRamwr) begin
         curAction = CUR_HOME;
      end else if (i_pixel_en_pls) begin
         if (curX < winXe) begin
            curAction = CUR_STEP_X;
         end else if (curY < winYe) begin
            curAction = CUR_NEXT_ROW;
         end else begin
            curAction = CUR_WRAP;
         end
      end
   end

   // Cursor register. Moving down a row adds the stride to the row offset
   // instead of multiplying, and homing reloads the precomputed offset of
   // the window's first row. The frame-done pulse follows a wrap by a cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         curX      <= '0;
         curY      <= '0;
         rowBase   <= '0;
         frameDone <= 1'b0;
      end else begin
         frameDone <= (curAction == CUR_WRAP);
         case (curAction)
            CUR_HOME, CUR_WRAP: begin
               curX    <= winXs;
               curY    <= winYs;
               rowBase <= ysBase;
            end
            CUR_STEP_X: begin
               curX <= curX + 16'd1;
            end
            CUR_NEXT_ROW: begin
               curX    <= winXs;
               curY    <= curY + 16'd1;
               rowBase <= rowBase + ROW_STEP;
            end
            default: begin
            end
         endcase
      end
   end

   // FIFO handshake. A pop in the same cycle frees the slot a push needs,
   // so a full FIFO that is also being drained still accepts the pixel.
   always_comb begin
      fifoFull  = (fifoCount == CNT_W'(FIFO_DEPTH));
      fifoPop   = (fifoCount != '0) && i_wr_ready;
      wantPush  = pixelLive && inBounds;
      fifoPush  = wantPush && (!fifoFull || fifoPop);
      dropPixel = wantPush && fifoFull && !fifoPop;
   end

   // FIFO storage. The entries need no reset because the outputs are
   // masked whenever the FIFO is empty.
   always_ff @(posedge i_clk) begin
      if (fifoPush) begin
         memAddr[wrPtr] <= pixAddr;
         memData[wrPtr] <= i_pixel_data;
      end
   end

   // FIFO pointers, occupancy and the sticky overflow flag. Reset empties
   // the FIFO at once, so pending writes are abandoned mid-transfer.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         fifoCount <= '0;
         ovfFlag   <= 1'b0;
      end else begin
         if (fifoPush) begin
            wrPtr <= wrPtr + PTR_W'(1);
         end
         if (fifoPop) begin
            rdPtr <= rdPtr + PTR_W'(1);
         end
         case ({fifoPush, fifoPop})
            2'b10:   fifoCount <= fifoCount + CNT_W'(1);
            2'b01:   fifoCount <= fifoCount - CNT_W'(1);
            default: fifoCount <= fifoCount;
         endcase
         if (dropPixel) begin
            ovfFlag <= 1'b1;
         end
      end
   end

   // Present the FIFO head to the arbiter, forced to zero while empty.
   always_comb begin
      o_wr_valid       = (fifoCount != '0);
      o_wr_addr        = o_wr_valid ? memAddr[rdPtr] : '0;
      o_wr_data        = o_wr_valid ? memData[rdPtr] : '0;
      o_frame_done_pls = frameDone;
      o_ovf            = ovfFlag;
   end

endmodule

// File: tb/tb_fb_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fb_write_ctrl
//
// Drives fb_write_ctrl one clock cycle per vector from a table of directed
// stimulus records with hand-computed outputs, then runs a few hand-written
// sequences for back-pressure, overflow and reset in the middle of a burst.
// Inputs change on the falling edge; outputs are compared on the next
// falling edge, after the rising edge that consumed the inputs.
// ---------------------------------------------------------------------------
module tb_fb_write_ctrl;

   localparam int ADDR_W = 17;

   logic              clock = 1'b0;
   logic              reset;
   logic [7:0]        instData;
   logic              instEn;
   logic [31:0]       colAddr;
   logic              colEn;
   logic [31:0]       rowAddr;
   logic              rowEn;
   logic [15:0]       pixelData;
   logic              pixelEn;
   logic [ADDR_W-1:0] wrAddr;
   logic [15:0]       wrData;
   logic              wrValid;
   logic              wrReady;
   logic              frameDone;
   logic              ovf;

   int passCount  = 0;
   int checkCount = 0;

   typedef struct {
      logic              rst;
      logic              instEn;
      logic [7:0]        inst;
      logic              colEn;
      logic [31:0]       col;
      logic              rowEn;
      logic [31:0]       row;
      logic              pixEn;
      logic [15:0]       pix;
      logic              ready;
      logic              expValid;
      logic [ADDR_W-1:0] expAddr;
      logic [15:0]       expData;
      logic              expDone;
   } vec_t;

   vec_t vecTable[$];

   // Free-running 100 MHz clock.
   always #5 clock = ~clock;

   fb_write_ctrl #(
      .H_RES(480), .V_RES(272), .ADDR_W(ADDR_W), .FIFO_DEPTH(4)
   ) dut (
      .i_clk(clock),
      .i_rst(reset),
      .i_inst_data(instData),
      .i_inst_en_pls(instEn),
      .i_col_addr(colAddr),
      .i_col_addr_en_pls(colEn),
      .i_row_addr(rowAddr),
      .i_row_addr_en_pls(rowEn),
      .i_pixel_data(pixelData),
      .i_pixel_en_pls(pixelEn),
      .o_wr_addr(wrAddr),
      .o_wr_data(wrData),
      .o_wr_valid(wrValid),
      .i_wr_ready(wrReady),
      .o_frame_done_pls(frameDone),
      .o_ovf(ovf)
   );

   // Record builders: an idle cycle with ready high and all outputs low.
   function automatic vec_t idleV();
      vec_t v;
      v = '{default: '0};
      v.ready = 1'b1;
      return v;
   endfunction

   function automatic vec_t rstV();
      vec_t v = idleV();
      v.rst = 1'b1;
      return v;
   endfunction

   function automatic vec_t cmdV(input logic [7:0] c);
      vec_t v = idleV();
      v.instEn = 1'b1;
      v.inst   = c;
      return v;
   endfunction

   function automatic vec_t colV(input logic [15:0] xs, input logic [15:0] xe);
      vec_t v = idleV();
      v.colEn = 1'b1;
      v.col   = {xs, xe};
      return v;
   endfunction

   function automatic vec_t rowV(input logic [15:0] ys, input logic [15:0] ye);
      vec_t v = idleV();
      v.rowEn = 1'b1;
      v.row   = {ys, ye};
      return v;
   endfunction

   function automatic vec_t pixV(input logic [15:0] d);
      vec_t v = idleV();
      v.pixEn = 1'b1;
      v.pix   = d;
      return v;
   endfunction

   // A pixel that must appear at the FIFO head with the given address.
   function automatic vec_t pixExp(input logic [15:0] d, input logic [ADDR_W-1:0] a, input logic done);
      vec_t v = pixV(d);
      v.expValid = 1'b1;
      v.expAddr  = a;
      v.expData  = d;
      v.expDone  = done;
      return v;
   endfunction

   // Drive one cycle of inputs on a falling edge and advance to the next one.
   task automatic applyStimulus(input vec_t v);
      reset     = v.rst;
      instEn    = v.instEn;
      instData  = v.inst;
      colEn     = v.colEn;
      colAddr   = v.col;
      rowEn     = v.rowEn;
      rowAddr   = v.row;
      pixelEn   = v.pixEn;
      pixelData = v.pix;
      wrReady   = v.ready;
      @(posedge clock);
      @(negedge clock);
   endtask

   // Compare every output against the expected values in one check.
   task automatic checkOutput(input string name, input logic eValid, input logic [ADDR_W-1:0] eAddr,
                              input logic [15:0] eData, input logic eOvf, input logic eDone);
      checkCount++;
      if (wrValid !== eValid || wrAddr !== eAddr || wrData !== eData || ovf !== eOvf || frameDone !== eDone) begin
         $display("[TB] FAIL %s: got valid=%0b addr=%0d data=%h ovf=%0b done=%0b, want valid=%0b addr=%0d data=%h ovf=%0b done=%0b",
                  name, wrValid, wrAddr, wrData, ovf, frameDone, eValid, eAddr, eData, eOvf, eDone);
      end else begin
         passCount++;
      end
   endtask

   // Single pixel with an explicit ready level, for the back-pressure runs.
   task automatic pixelWithReady(input logic [15:0] d, input logic r);
      vec_t v = pixV(d);
      v.ready = r;
      applyStimulus(v);
   endtask

   initial begin
      vec_t v;

      // Basic writes from reset: three pixels at addresses 0,1,2.
      vecTable.push_back(rstV());
      vecTable.push_back(cmdV(8'h2C));
      vecTable.push_back(pixExp(16'hA1A1, 0, 1'b0));
      vecTable.push_back(pixExp(16'hB2B2, 1, 1'b0));
      vecTable.push_back(pixExp(16'hC3C3, 2, 1'b0));
      vecTable.push_back(idleV());
      // 2x2 window at (10,5): row offset 2400, wrap and frame-done pulse.
      vecTable.push_back(colV(16'd10, 16'd11));
      vecTable.push_back(rowV(16'd5, 16'd6));
      vecTable.push_back(cmdV(8'h2C));
      vecTable.push_back(pixExp(16'h1001, 2410, 1'b0));
      vecTable.push_back(pixExp(16'h1002, 2411, 1'b0));
      vecTable.push_back(pixExp(16'h1003, 2890, 1'b0));
      vecTable.push_back(pixExp(16'h1004, 2891, 1'b1));
      vecTable.push_back(pixExp(16'h1005, 2410, 1'b0));
      // A non-RAMWR command leaves the cursor at (11,5).
      vecTable.push_back(cmdV(8'h2A));
      vecTable.push_back(pixExp(16'h1006, 2411, 1'b0));
      // Column pulse with a pixel: the pixel uses XE=11, the next ones XE=479.
      v = pixExp(16'h1007, 2890, 1'b0);
      v.colEn = 1'b1;
      v.col   = {16'd0, 16'd479};
      vecTable.push_back(v);
      vecTable.push_back(pixExp(16'h1008, 2891, 1'b0));
      vecTable.push_back(pixExp(16'h1009, 2892, 1'b0));
      // Clamped windows: XE<XS gives a one-column window, YE<YS one row.
      vecTable.push_back(rstV());
      vecTable.push_back(colV(16'd20, 16'd5));
      vecTable.push_back(cmdV(8'h2C));
      vecTable.push_back(pixExp(16'h2001, 20, 1'b0));
      vecTable.push_back(pixExp(16'h2002, 500, 1'b0));
      vecTable.push_back(pixExp(16'h2003, 980, 1'b0));
      vecTable.push_back(rowV(16'd3, 16'd1));
      vecTable.push_back(cmdV(8'h2C));
      vecTable.push_back(pixExp(16'h2004, 1460, 1'b1));
      vecTable.push_back(pixExp(16'h2005, 1460, 1'b1));
      // RAMWR and a pixel together: pixel dropped, cursor homed to (0,0).
      vecTable.push_back(rstV());
      vecTable.push_back(pixExp(16'h3001, 0, 1'b0));
      vecTable.push_back(pixExp(16'h3002, 1, 1'b0));
      v = cmdV(8'h2C);
      v.pixEn = 1'b1;
      v.pix   = 16'h3003;
      vecTable.push_back(v);
      vecTable.push_back(pixExp(16'h3004, 0, 1'b0));
      // Window straddling the right panel edge.
      vecTable.push_back(rstV());
      vecTable.push_back(colV(16'd479, 16'd480));
      vecTable.push_back(rowV(16'd0, 16'd0));
      vecTable.push_back(cmdV(8'h2C));
      vecTable.push_back(pixExp(16'h4001, 479, 1'b0));
`ifdef FB_BOUNDS_CHECK_EN
      v = pixV(16'h4002);
      v.expDone = 1'b1;
      vecTable.push_back(v);
`else
      vecTable.push_back(pixExp(16'h4002, 480, 1'b1));
`endif
      vecTable.push_back(idleV());

      reset     = 1'b1;
      instEn    = 1'b0;
      instData  = '0;
      colEn     = 1'b0;
      colAddr   = '0;
      rowEn     = 1'b0;
      rowAddr   = '0;
      pixelEn   = 1'b0;
      pixelData = '0;
      wrReady   = 1'b1;
      @(negedge clock);
      checkOutput("reset", 1'b0, 0, 16'h0, 1'b0, 1'b0);

      for (int i = 0; i < vecTable.size(); i++) begin
         applyStimulus(vecTable[i]);
         checkOutput($sformatf("vec%0d", i), vecTable[i].expValid, vecTable[i].expAddr,
                     vecTable[i].expData, 1'b0, vecTable[i].expDone);
      end

      // Full FIFO with a pop in the same cycle still accepts the pixel.
      applyStimulus(rstV());
      for (int i = 0; i < 4; i++) pixelWithReady(16'h6000 + 16'(i), 1'b0);
      checkOutput("fullHead", 1'b1, 0, 16'h6000, 1'b0, 1'b0);
      pixelWithReady(16'h6004, 1'b1);
      checkOutput("fullPushPop", 1'b1, 1, 16'h6001, 1'b0, 1'b0);
      for (int i = 2; i < 5; i++) begin
         applyStimulus(idleV());
         checkOutput($sformatf("fullDrain%0d", i), 1'b1, ADDR_W'(i), 16'h6000 + 16'(i), 1'b0, 1'b0);
      end
      applyStimulus(idleV());
      checkOutput("fullEmpty", 1'b0, 0, 16'h0, 1'b0, 1'b0);

      // Six pixels against a stalled arbiter: four kept, overflow flagged.
      applyStimulus(rstV());
      for (int i = 0; i < 4; i++) pixelWithReady(16'h5000 + 16'(i), 1'b0);
      checkOutput("ovfNotYet", 1'b1, 0, 16'h5000, 1'b0, 1'b0);
      pixelWithReady(16'h5004, 1'b0);
      checkOutput("ovfSet", 1'b1, 0, 16'h5000, 1'b1, 1'b0);
      pixelWithReady(16'h5005, 1'b0);
      v = idleV();
      v.ready = 1'b0;
      applyStimulus(v);
      checkOutput("ovfHeld", 1'b1, 0, 16'h5000, 1'b1, 1'b0);
      for (int i = 1; i < 4; i++) begin
         applyStimulus(idleV());
         checkOutput($sformatf("ovfDrain%0d", i), 1'b1, ADDR_W'(i), 16'h5000 + 16'(i), 1'b1, 1'b0);
      end
      applyStimulus(idleV());
      checkOutput("ovfEmpty", 1'b0, 0, 16'h0, 1'b1, 1'b0);
      pixelWithReady(16'h5006, 1'b1);
      checkOutput("ovfCursor", 1'b1, 6, 16'h5006, 1'b1, 1'b0);

      // Reset with three writes pending empties the FIFO immediately.
      applyStimulus(rstV());
      for (int i = 0; i < 3; i++) pixelWithReady(16'h7000 + 16'(i), 1'b0);
      checkOutput("rstPending", 1'b1, 0, 16'h7000, 1'b0, 1'b0);
      reset   = 1'b1;
      pixelEn = 1'b0;
      #1;
      checkOutput("rstSameCycle", 1'b0, 0, 16'h0, 1'b0, 1'b0);
      @(posedge clock);
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(idleV());
         checkOutput($sformatf("rstNoWrite%0d", i), 1'b0, 0, 16'h0, 1'b0, 1'b0);
      end
      pixelWithReady(16'h7009, 1'b1);
      checkOutput("rstCursor", 1'b1, 0, 16'h7009, 1'b0, 1'b0);
      applyStimulus(idleV());

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
